// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared phase enum, 640x480@60 default timing, total helper.
package vga_timing_pkg;

    // Phase of one raster axis; both horizontal and vertical FSMs use it.
    typedef enum logic [1:0] {
        ACT = 2'd0,
        FP  = 2'd1,
        SYN = 2'd2,
        BP  = 2'd3
    } phase_t;

    localparam int POS_W   = 10;
    localparam int POS_MAX = 1 << POS_W;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Length of one axis (pixels per line or lines per frame).
    function automatic int axis_total(input int disp, input int front,
                                      input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    function automatic int h_total(input int disp, input int front,
                                   input int sync, input int back);
        return axis_total(disp, front, sync, back);
    endfunction

    function automatic int v_total(input int disp, input int front,
                                   input int sync, input int back);
        return axis_total(disp, front, sync, back);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: position counter plus ACT/FP/SYN/BP phase FSM for one axis.
// Exposes next-state position/phase so the top can register flags that line
// up with the position on the same cycle.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY = DEF_H_DISPLAY,
    parameter int FRONT   = DEF_H_FRONT,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BACK    = DEF_H_BACK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    output logic [POS_W-1:0] o_pos,
    output logic [POS_W-1:0] o_pos_nxt,
    output phase_t           o_state_nxt,
    output logic             o_wrap
);

    localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);
    localparam logic [POS_W-1:0] LAST      = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] FP_START  = POS_W'(DISPLAY);
    localparam logic [POS_W-1:0] SYN_START = POS_W'(DISPLAY + FRONT);
    localparam logic [POS_W-1:0] BP_START  = POS_W'(DISPLAY + FRONT + SYNC);

    // Elaboration guards: counters are 10 bits and every phase must exist.
    if (TOTAL > POS_MAX) begin : g_bad_total
        $error("vga_axis_counter: total %0d exceeds %0d", TOTAL, POS_MAX);
    end
    if (DISPLAY < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_phase
        $error("vga_axis_counter: every phase length must be at least 1");
    end

    logic [POS_W-1:0] r_pos;
    phase_t           r_state;
    logic [POS_W-1:0] w_pos_nxt;
    phase_t           w_state_nxt;
    logic             w_wrap;

    // State register; reset parks on the last blanking position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos   <= LAST;
            r_state <= BP;
        end else begin
            r_pos   <= w_pos_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Next position and phase; phase changes on the tick reaching a boundary.
    always_comb begin
        w_pos_nxt   = r_pos;
        w_state_nxt = r_state;
        w_wrap      = 1'b0;
        if (i_tick) begin
            if (r_pos == LAST) begin
                w_pos_nxt = '0;
                w_wrap    = 1'b1;
            end else begin
                w_pos_nxt = r_pos + POS_W'(1);
            end
            case (r_state)
                ACT:     if (w_pos_nxt == FP_START)  w_state_nxt = FP;
                FP:      if (w_pos_nxt == SYN_START) w_state_nxt = SYN;
                SYN:     if (w_pos_nxt == BP_START)  w_state_nxt = BP;
                BP:      if (w_wrap)                 w_state_nxt = ACT;
                default: w_state_nxt = BP;
            endcase
        end
    end

    assign o_pos       = r_pos;
    assign o_pos_nxt   = w_pos_nxt;
    assign o_state_nxt = w_state_nxt;
    assign o_wrap      = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source (hpos/vpos, visible, syncs, strobes,
// frame counter). Optional macro SYNC_DELAY_EN adds one pix_en-gated stage on
// hsync, vsync and visible to match the colour stage's sprite ROM read.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = DEF_H_DISPLAY,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_DISPLAY  = DEF_V_DISPLAY,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             visible,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [POS_W-1:0] frame_count
);

    localparam logic [POS_W-1:0] V_SYN_START = POS_W'(V_DISPLAY + V_FRONT);
    localparam logic H_ACTIVE = H_SYNC_POL;
    localparam logic V_ACTIVE = V_SYNC_POL;

    logic [POS_W-1:0] w_hpos_nxt;
    logic [POS_W-1:0] w_vpos_nxt;
    phase_t           w_hstate_nxt;
    phase_t           w_vstate_nxt;
    logic             w_h_wrap;
    logic             w_unused_v_wrap;

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (pix_en),
        .o_pos       (hpos),
        .o_pos_nxt   (w_hpos_nxt),
        .o_state_nxt (w_hstate_nxt),
        .o_wrap      (w_h_wrap)
    );

    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (w_h_wrap),
        .o_pos       (vpos),
        .o_pos_nxt   (w_vpos_nxt),
        .o_state_nxt (w_vstate_nxt),
        .o_wrap      (w_unused_v_wrap)
    );

    logic w_visible_nxt;
    logic w_hsync_nxt;
    logic w_vsync_nxt;
    logic w_fc_inc;

    // Flags decoded from next-state values so they align with hpos/vpos.
    always_comb begin
        w_visible_nxt = (w_hstate_nxt == ACT) && (w_vstate_nxt == ACT);
        w_hsync_nxt   = (w_hstate_nxt == SYN) ? H_ACTIVE : ~H_ACTIVE;
        w_vsync_nxt   = (w_vstate_nxt == SYN) ? V_ACTIVE : ~V_ACTIVE;
        w_fc_inc      = w_h_wrap && (w_vstate_nxt == SYN) &&
                        (w_vpos_nxt == V_SYN_START);
    end

    logic             r_visible;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_line_start;
    logic             r_frame_start;
    logic [POS_W-1:0] r_frame_count;

    // Output registers; next-state values equal current ones when pix_en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_visible     <= 1'b0;
            r_hsync       <= ~H_ACTIVE;
            r_vsync       <= ~V_ACTIVE;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_visible     <= w_visible_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_line_start  <= (w_hpos_nxt == '0);
            r_frame_start <= (w_hpos_nxt == '0) && (w_vpos_nxt == '0);
            if (w_fc_inc) r_frame_count <= r_frame_count + POS_W'(1);
        end
    end

`ifdef SYNC_DELAY_EN
    logic r_visible_d;
    logic r_hsync_d;
    logic r_vsync_d;

    // One pixel of delay on the colour-facing signals.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_visible_d <= 1'b0;
            r_hsync_d   <= ~H_ACTIVE;
            r_vsync_d   <= ~V_ACTIVE;
        end else if (pix_en) begin
            r_visible_d <= r_visible;
            r_hsync_d   <= r_hsync;
            r_vsync_d   <= r_vsync;
        end
    end

    assign visible = r_visible_d;
    assign hsync   = r_hsync_d;
    assign vsync   = r_vsync_d;
`else
    assign visible = r_visible;
    assign hsync   = r_hsync;
    assign vsync   = r_vsync;
`endif

    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default 640x480 instance and on a
// tiny 8x6 raster instance used for whole-frame and frame_count wrap checks.
module tb_vga_timing_gen;

`ifdef SYNC_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    logic [9:0] hpos, vpos, frame_count;
    logic       visible, hsync, vsync, line_start, frame_start;
    logic [9:0] s_hpos, s_vpos, s_frame_count;
    logic       s_visible, s_hsync, s_vsync, s_line_start, s_frame_start;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hpos        (hpos),
        .vpos        (vpos),
        .visible     (visible),
        .hsync       (hsync),
        .vsync       (vsync),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    // Small raster: H 4/1/2/1 (8), V 3/1/1/1 (6) -> 48 ticks per frame.
    vga_timing_gen #(
        .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_DISPLAY (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
    ) u_sml (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hpos        (s_hpos),
        .vpos        (s_vpos),
        .visible     (s_visible),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .line_start  (s_line_start),
        .frame_start (s_frame_start),
        .frame_count (s_frame_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vis_n, vis_bad, hs_n, hs_first, hs_last, ls_n, pos_bad, exp_h;
        int fs_n, fs_last, fs_bad, vs_n, vis_sn;
        logic ev, ev_prev;

        rst = 1'b1; pix_en = 1'b0;
        tick(); tick();
        chk("rst_hpos", hpos, 799);
        chk("rst_vpos", vpos, 524);
        chk("rst_visible", visible, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_line_start", line_start, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_s_hpos", s_hpos, 7);
        chk("rst_s_vpos", s_vpos, 5);

        // First tick after reset lands on (0,0).
        rst = 1'b0; pix_en = 1'b1;
        tick();
        chk("first_hpos", hpos, 0);
        chk("first_vpos", vpos, 0);
        chk("first_line_start", line_start, 1);
        chk("first_frame_start", frame_start, 1);
        chk("first_visible", visible, (DLY != 0) ? 0 : 1);
        chk("first_hsync", hsync, 1);
        chk("first_vsync", vsync, 1);

        // One full line of the default raster.
        vis_n = 0; vis_bad = 0; hs_n = 0; hs_first = -1; hs_last = -1;
        ls_n = 0; pos_bad = 0; ev_prev = 1'b0;
        for (int i = 0; i < 800; i++) begin
            ev = (i < 640);
            if (visible) vis_n++;
            if (visible !== ((DLY != 0) ? ev_prev : ev)) vis_bad++;
            ev_prev = ev;
            if (hsync == 1'b0) begin
                hs_n++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (line_start) ls_n++;
            if (hpos != 10'(i)) pos_bad++;
            tick();
        end
        chk("line_visible_cnt", vis_n, 640);
        chk("line_visible_vs_pos", vis_bad, 0);
        chk("line_hsync_cnt", hs_n, 96);
        chk("line_hsync_first", hs_first, 656 + DLY);
        chk("line_hsync_last", hs_last, 751 + DLY);
        chk("line_start_cnt", ls_n, 1);
        chk("line_hpos_seq", pos_bad, 0);
        chk("wrap_hpos", hpos, 0);
        chk("wrap_vpos", vpos, 1);
        chk("wrap_line_start", line_start, 1);
        chk("wrap_frame_start", frame_start, 0);

        // pix_en toggling: position only moves on enabled clocks.
        exp_h = 0;
        for (int i = 0; i < 10; i++) begin
            pix_en = 1'b1;
            tick();
            exp_h++;
            chk("alt_hpos_on", hpos, exp_h);
            pix_en = 1'b0;
            tick();
            chk("alt_hpos_off", hpos, exp_h);
            chk("alt_vpos_off", vpos, 1);
            chk("alt_visible_off", visible, 1);
            chk("alt_line_start_off", line_start, 0);
        end

        // Reset mid-line at hpos 300 with pix_en high.
        pix_en = 1'b1;
        repeat (290) tick();
        chk("pre_rst_hpos", hpos, 300);
        chk("pre_rst_vpos", vpos, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; pix_en = 1'b0;
        chk("mid_rst_hpos", hpos, 799);
        chk("mid_rst_vpos", vpos, 524);
        chk("mid_rst_visible", visible, 0);
        chk("mid_rst_hsync", hsync, 1);
        chk("mid_rst_s_fc", s_frame_count, 0);
        chk("mid_rst_s_hpos", s_hpos, 7);
        chk("mid_rst_s_vpos", s_vpos, 5);
        tick();
        chk("idle_hpos", hpos, 799);

        // Small raster: 1024 frames from (0,0), frame_count wraps back to 0.
        pix_en = 1'b1;
        tick();
        fs_n = 0; fs_last = -1; fs_bad = 0; vs_n = 0; vis_sn = 0;
        for (int t = 0; t < 49152; t++) begin
            if (s_frame_start) begin
                if (fs_last >= 0 && (t - fs_last) != 48) fs_bad++;
                fs_last = t;
                fs_n++;
            end
            if (t < 48) begin
                if (s_vsync == 1'b0) vs_n++;
                if (s_visible) vis_sn++;
            end
            if (t == 31) chk("s_fc_before", s_frame_count, 0);
            if (t == 32) begin
                chk("s_fc_first", s_frame_count, 1);
                chk("s_vpos_syn", s_vpos, 4);
                chk("s_hpos_syn", s_hpos, 0);
            end
            if (t == 32 + 48 * 1022) chk("s_fc_1023", s_frame_count, 1023);
            if (t == 32 + 48 * 1023) chk("s_fc_wrap", s_frame_count, 0);
            tick();
        end
        chk("s_vsync_cnt", vs_n, 8);
        chk("s_visible_cnt", vis_sn, 12);
        chk("s_frame_start_cnt", fs_n, 1024);
        chk("s_frame_spacing", fs_bad, 0);
        chk("s_end_hpos", s_hpos, 0);
        chk("s_end_vpos", s_vpos, 0);
        chk("s_end_frame_start", s_frame_start, 1);
        chk("s_end_fc", s_frame_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
